mem_port_arbiter: RTL

Arbitrates the single-port instruction/data RAM between the instruction-fetch requester and the load/store requester of the pipeline. One access is in flight at a time. Read data is returned to the winning requester after a fixed RAM latency. Data-side requests have priority, with a starvation limit that guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port instruction/data RAM between the instruction-fetch
//   requester (if_*) and the load/store requester (dm_*). Only one access is
//   in flight at a time. Read data returns to the requester that won the
//   access, RD_LATENCY+2 cycles after its grant.
//
//   Priority: data-side requests win contested cycles. After STARVE_LIMIT
//   consecutive contested data wins, fetch is forced to win.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   if_req/if_addr        fetch read request, held until if_gnt
//   if_gnt                fetch request accepted this cycle (combinational)
//   if_rvalid/if_rdata    one-cycle pulse with the fetch read data (data held)
//   dm_req/dm_we/dm_addr/dm_wdata  load/store request, held until dm_gnt
//   dm_gnt                load/store request accepted this cycle (combinational)
//   dm_rvalid/dm_rdata    one-cycle pulse with load read data (data held)
//   ram_addr/ram_wdata/ram_we  registered RAM controls
//   ram_rdata             RAM read data, valid RD_LATENCY cycles after ram_addr
//   busy                  an access is in flight
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT
  } state_t;

  localparam logic [2:0] LAT_LOAD   = 3'(RD_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [2:0] lat_q, lat_d;
  logic [3:0] starve_cnt, starve_d;
  logic       src_dm_q;
  logic       rd_done;

  // Grant decision. Gated by rst_n so no grant is visible while in reset.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (if_req && dm_req) begin
        if (starve_cnt == STARVE_MAX) begin
          if_gnt = 1'b1;
        end else begin
          dm_gnt = 1'b1;
        end
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end
    end
  end

  // Starvation counter: only contested data wins move it; any fetch grant clears it.
  always_comb begin
    starve_d = starve_cnt;
    if (if_gnt) begin
      starve_d = '0;
    end else if (dm_gnt && if_req && (starve_cnt != STARVE_MAX)) begin
      starve_d = starve_cnt + 4'd1;
    end
  end

  // Next state. WAIT is entered with lat = RD_LATENCY-1 and read data is
  // sampled on the edge leaving WAIT with lat == 0.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    rd_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_gnt || dm_gnt) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ram_we) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          lat_d   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = IDLE;
          rd_done = 1'b1;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      starve_cnt <= '0;
      src_dm_q   <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      starve_cnt <= starve_d;
      ram_we     <= 1'b0;
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;

      // Capture the winner; fetch never writes and leaves ram_wdata as is.
      if (if_gnt) begin
        ram_addr <= if_addr;
        src_dm_q <= 1'b0;
      end else if (dm_gnt) begin
        ram_addr  <= dm_addr;
        ram_wdata <= dm_wdata;
        ram_we    <= dm_we;
        src_dm_q  <= 1'b1;
      end

      if (rd_done) begin
        if (src_dm_q) begin
          dm_rdata  <= ram_rdata;
          dm_rvalid <= 1'b1;
        end else begin
          if_rdata  <= ram_rdata;
          if_rvalid <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule
